// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed 4-digit 7-segment scan driver with frame-aligned double buffering.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
`default_nettype none

module seg_scan_mux #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  bcd,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick,
  output logic        pending
);

  localparam logic [23:0] DIV_LAST = 24'(TICK_DIV - 1);

  logic [23:0] div_cnt_q, div_cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [19:0] shadow_q, shadow_d;
  logic [19:0] display_q, display_d;
  logic [3:0]  an_q, an_d;
  logic [3:0]  bcd_q, bcd_d;
  logic        dp_q, dp_d;
  logic        frame_tick_q, frame_tick_d;
  logic        pending_q, pending_d;

  logic        tick;
  logic        wrap;
  logic        blank;
  logic [19:0] new_val;

  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    wrap      = tick && (idx_q == 2'd3);
    new_val   = {dp_in, data_in};
    div_cnt_d = tick ? 24'd0 : div_cnt_q + 24'd1;
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    shadow_d  = load ? new_val : shadow_q;
    // A load landing on the wrap edge bypasses the shadow so it is shown in this very frame.
    display_d = wrap ? (load ? new_val : shadow_q) : display_q;
    pending_d = wrap ? 1'b0 : (load ? 1'b1 : pending_q);
    frame_tick_d = wrap;
  end

  always_comb begin
    blank = 1'b0;
`ifdef SEG_SCAN_LZB_EN
    case (idx_d)
      2'd3:    blank = (display_d[15:12] == 4'd0);
      2'd2:    blank = (display_d[15:8]  == 8'd0);
      2'd1:    blank = (display_d[15:4]  == 12'd0);
      default: blank = 1'b0;
    endcase
`endif
    an_d  = an_q;
    bcd_d = bcd_q;
    dp_d  = dp_q;
    if (tick) begin
      an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_d);
      bcd_d = 4'(display_d[15:0] >> {idx_d, 2'b00});
      dp_d  = display_d[16 + idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= 24'd0;
      idx_q        <= 2'd0;
      shadow_q     <= 20'd0;
      display_q    <= 20'd0;
      an_q         <= 4'b1110;
      bcd_q        <= 4'd0;
      dp_q         <= 1'b0;
      frame_tick_q <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      an_q         <= an_d;
      bcd_q        <= bcd_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
      pending_q    <= pending_d;
    end
  end

  assign an         = an_q;
  assign bcd        = bcd_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;
  assign pending    = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
// Testbench for seg_scan_mux: directed and random loads checked against a cycle-count based model.
`default_nettype none

module tb_seg_scan_mux;

  localparam int TD    = 4;
  localparam int FRAME = 4 * TD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = 16'd0;
  logic [3:0]  dp_in = 4'd0;
  logic [3:0]  bcd;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;
  logic        pending;

  seg_scan_mux #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
    .bcd(bcd), .dp(dp), .an(an), .frame_tick(frame_tick), .pending(pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model: edges since reset release, plus the two buffers and the pending flag.
  int          m_t;
  logic [19:0] m_shadow, m_display;
  logic        m_pending;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, m_t, obs, expv);
    end
  endtask

  function automatic logic [3:0] exp_an(int t, logic [19:0] disp);
    int d;
    d = (t / TD) % 4;
`ifdef SEG_SCAN_LZB_EN
    if (d > 0 && (disp[15:0] >> (4 * d)) == 0) return 4'b1111;
`endif
    return ~(4'b0001 << d);
  endfunction

  task automatic check_all();
    int d;
    d = (m_t / TD) % 4;
    chk("an",         {28'd0, an},          {28'd0, exp_an(m_t, m_display)});
    chk("bcd",        {28'd0, bcd},         (32'(m_display[15:0]) >> (4 * d)) & 32'hF);
    chk("dp",         {31'd0, dp},          (32'(m_display[19:16]) >> d) & 32'h1);
    chk("frame_tick", {31'd0, frame_tick},  {31'd0, (m_t > 0) && (m_t % FRAME == 0)});
    chk("pending",    {31'd0, pending},     {31'd0, m_pending});
  endtask

  // Called at a negedge: drive inputs, take one rising edge, update model, check at next negedge.
  task automatic cycle(input logic ld, input logic [15:0] d, input logic [3:0] p);
    logic wrap;
    load = ld; data_in = d; dp_in = p;
    @(posedge clk);
    wrap = (m_t % FRAME) == FRAME - 1;
    if (wrap) begin
      m_display = ld ? {p, d} : m_shadow;
      m_pending = 1'b0;
    end else if (ld) begin
      m_pending = 1'b1;
    end
    if (ld) m_shadow = {p, d};
    m_t++;
    @(negedge clk);
    load = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'd0, 4'd0);
  endtask

  task automatic model_reset();
    m_t = 0; m_shadow = 20'd0; m_display = 20'd0; m_pending = 1'b0;
  endtask

  task automatic run_to_phase(input int ph);
    for (int i = 0; i < FRAME && (m_t % FRAME) != ph; i++) idle(1);
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_all();

    // Free-running scan over two frames with nothing loaded.
    idle(2 * FRAME);

    // Mid-frame load: shown only from the next wrap.
    run_to_phase(5);
    cycle(1'b1, 16'h1234, 4'b0100);
    idle(2 * FRAME);

    // Two loads in one frame: last one wins.
    run_to_phase(2);
    cycle(1'b1, 16'h1111, 4'b0000);
    idle(3);
    cycle(1'b1, 16'h9876, 4'b0001);
    idle(2 * FRAME);

    // Load exactly on the wrap edge.
    run_to_phase(FRAME - 1);
    cycle(1'b1, 16'h5555, 4'b1111);
    idle(FRAME + 2);

    // Leading-zero patterns.
    cycle(1'b1, 16'h0070, 4'b0000);
    idle(2 * FRAME);
    cycle(1'b1, 16'h0000, 4'b0000);
    idle(2 * FRAME);
    cycle(1'b1, 16'h0305, 4'b1010);
    idle(2 * FRAME);

    // Asynchronous reset in the digit-2 slot with a load pending.
    cycle(1'b1, 16'h4321, 4'b1111);
    idle(FRAME);
    run_to_phase(2 * TD + 1);
    cycle(1'b1, 16'h8888, 4'b1000);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    idle(2 * FRAME);

    // Random loads, including BCD codes 10..15.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)
        cycle(1'b1, 16'($urandom), 4'($urandom));
      else
        idle(1);
    end
    idle(2 * FRAME);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
